// File: rtl/pll_phase_ctl.sv
// Dynamic PLL phase-shift sequencer: steps one output counter toward a target phase.
// Optional step watchdog is enabled by defining PLL_PHASE_TIMEOUT_EN.
module pll_phase_ctl #(
  parameter int NUM_CH      = 2,
  parameter int PHASE_W     = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_ch,
  input  logic signed [PHASE_W-1:0] req_target,
  input  logic                      pll_locked,
  output logic                      phase_en,
  output logic                      updown,
  output logic [4:0]                cntsel,
  input  logic                      phase_done,
  output logic                      busy,
  output logic [NUM_CH*PHASE_W-1:0] cur_phase,
  output logic                      err
);

  typedef enum logic [2:0] {
    IDLE, CALC, PULSE, WAIT_LO, WAIT_HI, DONE
  } state_t;

  localparam logic [3:0]         NCH = NUM_CH[3:0];
  localparam logic [PHASE_W-1:0] ONE = 1;

  state_t state_q, state_d;

  logic                      sync0, done_s;
  logic [2:0]                ch_q;
  logic [PHASE_W-1:0]        target_q;
  logic [NUM_CH*PHASE_W-1:0] cur_q;
  logic [PHASE_W-1:0]        cur_sel;
  logic [PHASE_W:0]          delta;
  logic                      delta_pos;
  int                        base;
  logic                      capture, calc, step, err_d;

`ifdef PLL_PHASE_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TONE     = 1;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TMO_LAST);
`endif

  assign base      = int'(ch_q) * PHASE_W;
  assign cur_sel   = cur_q[base +: PHASE_W];
  assign delta     = {target_q[PHASE_W-1], target_q}
                   - {cur_sel[PHASE_W-1], cur_sel};
  assign delta_pos = !delta[PHASE_W] && (delta != '0);

  assign req_ready = (state_q == IDLE) && pll_locked;
  assign phase_en  = (state_q == PULSE) && pll_locked;
  assign busy      = (state_q != IDLE);
  assign cur_phase = cur_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    calc    = 1'b0;
    step    = 1'b0;
    err_d   = 1'b0;
    if (!pll_locked) begin
      // Loss of lock invalidates every tracked phase.
      state_d = IDLE;
      err_d   = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if ({1'b0, req_ch} < NCH) begin
              capture = 1'b1;
              state_d = CALC;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CALC: begin
          calc    = 1'b1;
          state_d = (delta == '0) ? DONE : PULSE;
        end
        PULSE: state_d = WAIT_LO;
        WAIT_LO: begin
          if (!done_s) state_d = WAIT_HI;
`ifdef PLL_PHASE_TIMEOUT_EN
          if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
`endif
        end
        WAIT_HI: begin
          if (done_s) begin
            step    = 1'b1;
            state_d = CALC;
          end
`ifdef PLL_PHASE_TIMEOUT_EN
          if (tmo_hit) begin
            step    = 1'b0;
            state_d = IDLE;
            err_d   = 1'b1;
          end
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err     <= 1'b0;
      sync0   <= 1'b0;
      done_s  <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= err_d;
      sync0   <= phase_done;
      done_s  <= sync0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      ch_q     <= '0;
      target_q <= '0;
      updown   <= 1'b0;
      cntsel   <= '0;
      cur_q    <= '0;
    end else begin
      if (capture) begin
        ch_q     <= req_ch;
        target_q <= req_target;
      end
      if (calc) begin
        updown <= delta_pos;
        cntsel <= {2'b00, ch_q};
      end
      if (!pll_locked) cur_q <= '0;
      else if (step)
        cur_q[base +: PHASE_W] <= updown ? cur_sel + ONE : cur_sel - ONE;
    end
  end

`ifdef PLL_PHASE_TIMEOUT_EN
  // Counts the whole handshake of one step, both wait phases together.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else if (state_q == WAIT_LO || state_q == WAIT_HI) tmo_q <= tmo_q + TONE;
    else tmo_q <= '0;
  end
`endif

endmodule

// File: tb/tb_pll_phase_ctl.sv
// Self-checking bench for pll_phase_ctl: vector table plus lock-loss,
// mid-step reset and (with PLL_PHASE_TIMEOUT_EN) watchdog sequences.
module tb_pll_phase_ctl;

  localparam int W = 10;

  logic          refclk = 0, rst = 1, req_valid = 0, req_ready;
  logic [2:0]    req_ch = 0;
  logic signed [W-1:0] req_target = 0;
  logic          pll_locked = 1, phase_en, updown, phase_done, busy, err;
  logic [4:0]    cntsel;
  logic [2*W-1:0] cur_phase;

  int n_vec = 0, n_bad = 0;
  logic hold_hi = 0;
  int   dcnt;

  pll_phase_ctl #(.NUM_CH(2), .PHASE_W(W), .TIMEOUT_CYC(16)) dut (
    .refclk(refclk), .rst(rst), .req_valid(req_valid),
    .req_ready(req_ready), .req_ch(req_ch), .req_target(req_target),
    .pll_locked(pll_locked), .phase_en(phase_en), .updown(updown),
    .cntsel(cntsel), .phase_done(phase_done), .busy(busy),
    .cur_phase(cur_phase), .err(err)
  );

  always #5 refclk = ~refclk;

  // PLL model: phase_done drops after the strobe, rises 4 cycles after it.
  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      phase_done <= 1'b1;
      dcnt       <= 0;
    end else if (phase_en && !hold_hi) begin
      phase_done <= 1'b0;
      dcnt       <= 3;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) phase_done <= 1'b1;
    end
  end

  typedef struct {
    logic [2:0]          ch;
    logic signed [W-1:0] tgt;
    int                  pulses;
    logic                up;
    int                  errs;
    int                  c0, c1;
    int                  busy_cyc;
    int                  err_at;
  } vec_t;

  vec_t sb[$];

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cp(int c);
    logic signed [W-1:0] v;
    v = cur_phase[c*W +: W];
    return int'(v);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge refclk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input vec_t v);
    vec_t e;
    int pulses = 0, errs = 0, bcyc = 0, dir_bad = 0;
    int n = 0, p_at = -1, e_at = -1;
    bit done = 0;
    @(negedge refclk);
    wait_ready();
    req_valid  = 1;
    req_ch     = v.ch;
    req_target = v.tgt;
    sb.push_back(v);
    @(posedge refclk);
    @(negedge refclk);
    req_valid = 0;
    while (!done && n < 2000) begin
      if (phase_en) begin
        pulses++;
        if (p_at < 0) p_at = n;
        if (updown !== v.up || cntsel !== {2'b00, v.ch}) dir_bad++;
      end
      if (err) begin
        errs++;
        if (e_at < 0 && p_at >= 0) e_at = n - p_at;
      end
      if (busy) bcyc++;
      else done = 1;
      if (!done) begin
        @(negedge refclk);
        n++;
      end
    end
    e = sb.pop_front();
    if (!done) chk("done_timeout", 0, 1);
    chk("pulses", pulses, e.pulses);
    chk("dir_sel", dir_bad, 0);
    chk("err", errs, e.errs);
    chk("cur0", cp(0), e.c0);
    chk("cur1", cp(1), e.c1);
    chk("ready_after", int'(req_ready), 1);
    if (e.busy_cyc >= 0) chk("busy_cyc", bcyc, e.busy_cyc);
    if (e.err_at >= 0) chk("err_at", e_at, e.err_at);
  endtask

  vec_t tab[7];

  initial begin
    int n;
    tab[0] = '{3'd1,  10'sd3, 3, 1'b1, 0,  0,  3, -1, -1};
    tab[1] = '{3'd1, -10'sd2, 5, 1'b0, 0,  0, -2, -1, -1};
    tab[2] = '{3'd0,  10'sd0, 0, 1'b0, 0,  0, -2,  2, -1};
    tab[3] = '{3'd5,  10'sd0, 0, 1'b0, 1,  0, -2,  0, -1};
    tab[4] = '{3'd0, -10'sd1, 1, 1'b0, 0, -1, -2, -1, -1};
    tab[5] = '{3'd1, -10'sd2, 0, 1'b0, 0, -1, -2,  2, -1};
    tab[6] = '{3'd0,  10'sd2, 3, 1'b1, 0,  2, -2, -1, -1};

    repeat (3) @(negedge refclk);
    chk("rst_phase_en", int'(phase_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_updown", int'(updown), 0);
    chk("rst_cntsel", int'(cntsel), 0);
    chk("rst_cur", int'(cur_phase), 0);
    rst = 0;

    foreach (tab[i]) do_req(tab[i]);

    // Lock loss during WAIT_HI of the second of three up-steps on ch1.
    @(negedge refclk);
    wait_ready();
    req_valid = 1; req_ch = 3'd1; req_target = 10'sd1;
    @(posedge refclk);
    @(negedge refclk);
    req_valid = 0;
    n = 0;
    for (int k = 0; k < 2 && n < 200; ) begin
      if (phase_en) k++;
      if (k < 2) begin
        @(negedge refclk);
        n++;
      end
    end
    chk("second_pulse_seen", int'(phase_en), 1);
    repeat (4) @(negedge refclk);
    chk("mid_cur1", cp(1), -1);
    chk("mid_busy", int'(busy), 1);
    pll_locked = 0;
    begin
      int errs = 0, rdy = 0, bsy = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge refclk);
        errs += int'(err);
        rdy  += int'(req_ready);
        bsy  += int'(busy);
      end
      chk("lock_err", errs, 1);
      chk("lock_ready", rdy, 0);
      chk("lock_busy", bsy, 0);
      chk("lock_cur", int'(cur_phase), 0);
    end
    pll_locked = 1;
    @(negedge refclk);
    chk("relock_ready", int'(req_ready), 1);

    // Reset asserted mid-step abandons the step.
    req_valid = 1; req_ch = 3'd1; req_target = 10'sd2;
    @(posedge refclk);
    @(negedge refclk);
    req_valid = 0;
    n = 0;
    while (!phase_en && n < 50) begin
      @(negedge refclk);
      n++;
    end
    chk("rst_step_pulse", int'(phase_en), 1);
    repeat (2) @(negedge refclk);
    #2 rst = 1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_updown", int'(updown), 0);
    chk("arst_cntsel", int'(cntsel), 0);
    chk("arst_phase_en", int'(phase_en), 0);
    repeat (2) @(negedge refclk);
    rst = 0;
    repeat (8) @(negedge refclk);
    chk("arst_cur", int'(cur_phase), 0);
    chk("arst_idle", int'(busy), 0);

`ifdef PLL_PHASE_TIMEOUT_EN
    // phase_done never falls: err registers one cycle after the 16th wait cycle.
    hold_hi = 1;
    do_req('{3'd0, 10'sd1, 1, 1'b1, 1, 0, 0, 18, 17});
    hold_hi = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
